// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues one word read at a time to
// instruction memory, and queues returned instructions with their PCs in a
// 2-entry buffer for decode. Redirects flush the buffer and squash any read
// that is still in flight.
module instr_fetch_unit #(
    parameter int              PC_W     = 8,
    parameter int              INSTR_W  = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [PC_W-1:0]    imem_req_addr,
    input  logic               imem_resp_valid,
    input  logic [INSTR_W-1:0] imem_resp_data,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               inst_valid,
    input  logic               inst_ready,
    output logic [INSTR_W-1:0] inst_data,
    output logic [PC_W-1:0]    inst_pc,
    output logic               busy
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_SQUASH} state_t;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    state_t          state, state_n;
    logic [PC_W-1:0] pc, pend_pc;
    entry_t          fifo [2];
    logic            rd_ptr, wr_ptr;
    logic [1:0]      count;

    logic req_fire, push, pop;

    // Issue only when the buffer has room for the word coming back, so a
    // push can never land on a full buffer.
    always_comb begin
        imem_req_valid = (state == S_REQ) && (count != 2'd2) && !reset;
        imem_req_addr  = pc;
        req_fire       = imem_req_valid && imem_req_ready;
        inst_valid     = (count != 2'd0) && !reset;
        inst_data      = fifo[rd_ptr].instr;
        inst_pc        = fifo[rd_ptr].pc;
        busy           = (state != S_REQ) && !reset;
        // A redirect flushes the buffer, so any same-cycle push/pop is moot.
        push           = (state == S_WAIT) && imem_resp_valid && !redirect_valid;
        pop            = inst_valid && inst_ready && !redirect_valid;
    end

    // Next-state: a redirect turns an in-flight (or just-accepted) read into
    // one that must be drained and discarded.
    always_comb begin
        state_n = state;
        case (state)
            S_REQ: begin
                if (req_fire)
                    state_n = redirect_valid ? S_SQUASH : S_WAIT;
            end
            S_WAIT: begin
                if (imem_resp_valid)
                    state_n = S_REQ;
                else if (redirect_valid)
                    state_n = S_SQUASH;
            end
            S_SQUASH: begin
                if (imem_resp_valid)
                    state_n = S_REQ;
            end
            default: state_n = S_REQ;
        endcase
    end

    // State, PC and buffer occupancy; redirect has priority over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_REQ;
            pc      <= RESET_PC;
            pend_pc <= '0;
            count   <= 2'd0;
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
        end else begin
            state <= state_n;
            if (req_fire)
                pend_pc <= pc;
            if (redirect_valid)
                pc <= {redirect_pc[PC_W-1:2], 2'b00};
            else if (req_fire)
                pc <= pc + PC_W'(4);
            if (redirect_valid) begin
                count  <= 2'd0;
                rd_ptr <= 1'b0;
                wr_ptr <= 1'b0;
            end else begin
                if (push)
                    wr_ptr <= ~wr_ptr;
                if (pop)
                    rd_ptr <= ~rd_ptr;
                case ({push, pop})
                    2'b10:   count <= count + 2'd1;
                    2'b01:   count <= count - 2'd1;
                    default: count <= count;
                endcase
            end
        end
    end

    // Buffer storage needs no reset; occupancy qualifies every read.
    always_ff @(posedge clk) begin
        if (push)
            fifo[wr_ptr] <= '{pc: pend_pc, instr: imem_resp_data};
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a memory model answers reads with address-tagged
// words, a scoreboard holds the instructions decode should see, and a monitor
// compares every instruction consumed. Directed cycle checks cover timing,
// back-pressure, redirects, PC wrap and reset.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid, imem_req_ready;
    logic [7:0]  imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        inst_valid, inst_ready;
    logic [31:0] inst_data;
    logic [7:0]  inst_pc;
    logic        busy;

    // Second instance only proves a non-zero RESET_PC is honoured.
    logic        r2_req_valid, r2_inst_valid, r2_busy;
    logic [7:0]  r2_req_addr, r2_inst_pc;
    logic [31:0] r2_inst_data;

    typedef struct {
        logic [7:0]  pc;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   lat     = 1;

    logic       mem_pending;
    int         mem_cnt;
    logic [7:0] mem_addr;

    always #5 clk = ~clk;

    instr_fetch_unit #(.PC_W(8), .INSTR_W(32), .RESET_PC(8'h00)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_data(inst_data), .inst_pc(inst_pc), .busy(busy)
    );

    instr_fetch_unit #(.PC_W(8), .INSTR_W(32), .RESET_PC(8'hF8)) dut2 (
        .clk(clk), .reset(reset),
        .imem_req_valid(r2_req_valid), .imem_req_ready(1'b0),
        .imem_req_addr(r2_req_addr),
        .imem_resp_valid(1'b0), .imem_resp_data(32'h0),
        .redirect_valid(1'b0), .redirect_pc(8'h00),
        .inst_valid(r2_inst_valid), .inst_ready(1'b0),
        .inst_data(r2_inst_data), .inst_pc(r2_inst_pc), .busy(r2_busy)
    );

    function automatic logic [31:0] tag(input logic [7:0] a);
        return {a, 8'h13, ~a, 8'h37};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic expect_pc(input logic [7:0] a);
        exp_t e;
        e.pc   = a;
        e.data = tag(a);
        sb.push_back(e);
    endtask

    // Holds reset two cycles; returns at the negedge of cycle 1 with reset low.
    task automatic do_reset;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        reset          = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic to_cycle(input int from, input int to);
        for (int i = from; i < to; i++) @(negedge clk);
    endtask

    // Consume until the scoreboard is empty, then stop consuming.
    task automatic drain(input int budget);
        inst_ready = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sb.size() == 0) begin
                inst_ready = 1'b0;
                return;
            end
        end
        inst_ready = 1'b0;
        n_tests++;
        n_fail++;
        $display("FAIL drain_timeout: %0d instructions outstanding, required 0", sb.size());
        sb.delete();
    endtask

    // Memory model: one response per accepted request, lat cycles later.
    initial begin
        mem_pending     = 1'b0;
        mem_cnt         = 0;
        mem_addr        = 8'h00;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        forever begin
            @(negedge clk);
            #2;
            imem_resp_valid = 1'b0;
            if (reset) begin
                mem_pending = 1'b0;
            end else begin
                if (mem_pending) begin
                    mem_cnt--;
                    if (mem_cnt == 0) begin
                        imem_resp_valid = 1'b1;
                        imem_resp_data  = tag(mem_addr);
                        mem_pending     = 1'b0;
                    end
                end
                if (imem_req_valid && imem_req_ready) begin
                    mem_pending = 1'b1;
                    mem_cnt     = lat;
                    mem_addr    = imem_req_addr;
                end
            end
        end
    end

    // Monitor: every instruction decode consumes must match the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (!reset && inst_valid && inst_ready) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_inst: pc=%h data=%h, required none", inst_pc, inst_data);
                end else begin
                    e = sb.pop_front();
                    if (inst_pc !== e.pc || inst_data !== e.data) begin
                        n_fail++;
                        $display("FAIL inst: pc=%h data=%h, required pc=%h data=%h",
                                 inst_pc, inst_data, e.pc, e.data);
                    end
                end
            end
        end
    end

    initial begin
        logic [6:0] t1_req  = 7'b1010101;
        logic [6:0] t1_inst = 7'b1010100;
        logic [6:0] t1_busy = 7'b0101010;

        reset          = 1'b1;
        imem_req_ready = 1'b1;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 8'h00;

        // Reset state, observed during the second reset cycle.
        @(negedge clk);
        @(negedge clk);
        #4;
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_addr", 32'(imem_req_addr), 32'h00);
        check("rst_addr_f8", 32'(r2_req_addr), 32'hF8);

        // Zero-wait memory, decode always ready: one instruction every 2 cycles.
        lat = 1;
        do_reset();
        expect_pc(8'h00); expect_pc(8'h04); expect_pc(8'h08);
        inst_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge clk);
            #4;
            check($sformatf("t1_req_valid_c%0d", i + 1), 32'(imem_req_valid), 32'(t1_req[i]));
            check($sformatf("t1_inst_valid_c%0d", i + 1), 32'(inst_valid), 32'(t1_inst[i]));
            check($sformatf("t1_busy_c%0d", i + 1), 32'(busy), 32'(t1_busy[i]));
            if (t1_req[i])
                check($sformatf("t1_addr_c%0d", i + 1), 32'(imem_req_addr), 32'(i * 2));
        end
        @(negedge clk);
        inst_ready = 1'b0;
        check("t1_sb_empty", 32'(sb.size()), 32'd0);

        // Back-pressure: two entries buffered, issue blocked, then resumes.
        do_reset();
        to_cycle(1, 8);
        inst_ready = 1'b1;
        expect_pc(8'h00); expect_pc(8'h04); expect_pc(8'h08);
        #4;
        check("t2_full_inst_valid", 32'(inst_valid), 32'd1);
        check("t2_full_head_pc", 32'(inst_pc), 32'h00);
        check("t2_full_req_valid", 32'(imem_req_valid), 32'd0);
        check("t2_full_busy", 32'(busy), 32'd0);
        @(negedge clk);
        #4;
        check("t2_resume_req_valid", 32'(imem_req_valid), 32'd1);
        check("t2_resume_addr", 32'(imem_req_addr), 32'h08);
        check("t2_second_pc", 32'(inst_pc), 32'h04);
        drain(20);

        // Redirect to 0x41 while waiting; stale response arrives 3 cycles later.
        lat = 4;
        do_reset();
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 8'h41;
        #4;
        check("t3_wait_busy", 32'(busy), 32'd1);
        @(negedge clk);
        redirect_valid = 1'b0;
        #4;
        check("t3_squash_busy", 32'(busy), 32'd1);
        check("t3_squash_req_valid", 32'(imem_req_valid), 32'd0);
        to_cycle(3, 5);
        #4;
        check("t3_c5_resp", 32'(imem_resp_valid), 32'd1);
        check("t3_c5_inst_valid", 32'(inst_valid), 32'd0);
        @(negedge clk);
        lat = 1;
        #4;
        check("t3_restart_req_valid", 32'(imem_req_valid), 32'd1);
        check("t3_restart_addr", 32'(imem_req_addr), 32'h40);
        expect_pc(8'h40); expect_pc(8'h44);
        drain(20);

        // Redirect coinciding with a handshake, then with a response.
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 8'h80;
        #4;
        check("t4_hs_req_valid", 32'(imem_req_valid), 32'd1);
        @(negedge clk);
        redirect_valid = 1'b0;
        #4;
        check("t4_hs_busy", 32'(busy), 32'd1);
        check("t4_hs_inst_valid", 32'(inst_valid), 32'd0);
        @(negedge clk);
        #4;
        check("t4_hs_restart_addr", 32'(imem_req_addr), 32'h80);
        check("t4_hs_restart_valid", 32'(imem_req_valid), 32'd1);
        check("t4_hs_empty", 32'(inst_valid), 32'd0);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 8'hC4;
        #4;
        check("t4_resp_same_cycle", 32'(imem_resp_valid), 32'd1);
        @(negedge clk);
        redirect_valid = 1'b0;
        #4;
        check("t4_resp_empty", 32'(inst_valid), 32'd0);
        check("t4_resp_busy", 32'(busy), 32'd0);
        check("t4_resp_restart_addr", 32'(imem_req_addr), 32'hC4);
        expect_pc(8'hC4);
        drain(20);

        // Redirect with two entries buffered flushes them; low bits forced to 0.
        do_reset();
        to_cycle(1, 8);
        redirect_valid = 1'b1;
        redirect_pc    = 8'h22;
        @(negedge clk);
        redirect_valid = 1'b0;
        #4;
        check("t4c_flush_inst_valid", 32'(inst_valid), 32'd0);
        check("t4c_flush_addr", 32'(imem_req_addr), 32'h20);
        expect_pc(8'h20);
        drain(20);

        // Memory stall with redirect to 0xF8, then PC wrap-around.
        do_reset();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 8'hF8;
        @(negedge clk);
        redirect_valid = 1'b0;
        #4;
        check("t5_stall_req_valid", 32'(imem_req_valid), 32'd1);
        check("t5_stall_addr", 32'(imem_req_addr), 32'hF8);
        check("t5_stall_busy", 32'(busy), 32'd0);
        @(negedge clk);
        #4;
        check("t5_stall_hold_addr", 32'(imem_req_addr), 32'hF8);
        @(negedge clk);
        imem_req_ready = 1'b1;
        expect_pc(8'hF8); expect_pc(8'hFC); expect_pc(8'h00); expect_pc(8'h04);
        drain(40);

        // Reset mid-stream with the buffer full.
        do_reset();
        to_cycle(1, 8);
        #4;
        check("t6_pre_full", 32'(inst_valid), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #4;
        check("t6_rst_inst_valid", 32'(inst_valid), 32'd0);
        check("t6_rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #4;
        check("t6_post_inst_valid", 32'(inst_valid), 32'd0);
        check("t6_post_busy", 32'(busy), 32'd0);
        check("t6_post_addr", 32'(imem_req_addr), 32'h00);

        @(negedge clk);
        check("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch front end for the single-issue RISC-V core. It owns the 8-bit program counter and issues word reads to instruction memory over a valid/ready request channel, keeping at most one read outstanding. Returned instructions are queued in a 2-entry buffer with their PCs for the decode stage. Branch/jump redirects from execute flush the buffer and squash any in-flight read.

## Interface
- PC_W, 8: program counter and instruction address width (byte address)
- INSTR_W, 32: instruction width
- RESET_PC, 8'h00: PC value loaded on reset
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  reset, synchronous, active-high
- imem_req_valid  out  1  read request valid
- imem_req_ready  in  1  memory accepts the request this cycle
- imem_req_addr  out  PC_W  byte address of the request (current PC)
- imem_resp_valid  in  1  read data valid; exactly one response per accepted request, any cycle after acceptance
- imem_resp_data  in  INSTR_W  instruction word
- redirect_valid  in  1  one-cycle pulse: load new PC and flush
- redirect_pc  in  PC_W  redirect target; bits [1:0] forced to 0
- inst_valid  out  1  buffer head holds an instruction
- inst_ready  in  1  decode consumes the head this cycle
- inst_data  out  INSTR_W  head instruction
- inst_pc  out  PC_W  PC of head instruction
- busy  out  1  a memory read is outstanding or being squashed

## Operation
- State: pc, pend_pc, FSM {S_REQ, S_WAIT, S_SQUASH}, 2-entry FIFO of {pc, instr}, count 0..2.
- S_REQ: imem_req_valid = (count < 2) & !reset; imem_req_addr = pc. On valid & ready: pend_pc <= pc, pc <= pc + 4, go S_WAIT.
- S_WAIT: on imem_resp_valid, push {pend_pc, imem_resp_data}, go S_REQ.
- S_SQUASH: on imem_resp_valid, discard data, go S_REQ.
- pc increment is modulo 2^PC_W: 8'hFC + 4 = 8'h00.
- Redirect (highest priority): pc <= {redirect_pc[7:2], 2'b00}; count <= 0, so any same-cycle pop or push is discarded.
  - S_REQ, no handshake this cycle -> stay S_REQ.
  - S_REQ with handshake this cycle -> request is squashed, go S_SQUASH.
  - S_WAIT without resp -> S_SQUASH; S_WAIT with resp same cycle -> drop, S_REQ.
  - S_SQUASH without resp -> stay S_SQUASH; with resp -> drop, S_REQ.
- FIFO: pop when inst_valid & inst_ready; a simultaneous push and pop at count 1 or 2 leaves count unchanged and preserves order. Push never occurs at count 2; the issue rule guarantees this.
- inst_valid = (count != 0); inst_data and inst_pc come from the head entry and are stable while inst_valid & !inst_ready.
- busy = (state != S_REQ).
- Reset: pc = RESET_PC, state S_REQ, count 0, pend_pc 0. imem_req_valid, inst_valid and busy are 0 during the reset cycle. A response arriving after reset is not expected; memory is reset together with this block.

## Timing
- Request accepted at cycle N. Earliest response is at N+1. The instruction is visible on inst_valid at N+2. The next request can be issued at N+2.
- Peak throughput is 1 instruction per 2 cycles with zero-wait memory.
- Redirect at cycle R with no read in flight: a request to the target appears at R+1.
- Redirect at cycle R with a read in flight: the request to the target appears the cycle after the squashed response arrives.
- Flow control: the FIFO holding 2 entries blocks issue. Issue resumes the cycle after a pop brings count below 2.

## Test plan
- Reset, then zero-wait memory returning addr-tagged data, inst_ready=1 -> requests to 0x00, 0x04, 0x08 on cycles 1, 3, 5; inst_valid on cycles 3, 5, 7 with inst_pc 0x00, 0x04, 0x08.
- inst_ready=0 -> exactly 2 instructions buffered (pc 0x00, 0x04), imem_req_valid stays 0. Raising inst_ready pops in order and the request for 0x08 follows.
- Redirect to 0x41 while in S_WAIT, response arrives 3 cycles later -> stale data never appears on inst_valid. The next request address is 0x40, and the first delivered inst_pc is 0x40.
- Redirect on the same cycle as a request handshake and on the same cycle as a response -> both old reads are dropped, the FIFO is empty the next cycle, and fetch restarts at the target.
- Start at RESET_PC=8'hF8 -> inst_pc sequence 0xF8, 0xFC, 0x00, 0x04 (wrap-around).
- Assert reset mid-stream with 2 entries buffered -> the next cycle shows inst_valid=0, busy=0, imem_req_addr=RESET_PC.
